// File: rtl/fpcvt_pipe_if.sv
// Handshake bundle for the fixed-to-float converter: sample input side and
// result output side, each with its own valid/ready pair.
interface fpcvt_pipe_if #(
    parameter int unsigned IN_W  = 12,
    parameter int unsigned EXP_W = 3,
    parameter int unsigned MAN_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  D;
    logic             out_valid;
    logic             out_ready;
    logic             S;
    logic [EXP_W-1:0] E;
    logic [MAN_W-1:0] F;
    logic             sat;

    // Producer of samples / consumer of results.
    modport master (
        output in_valid, D, out_ready,
        input  in_ready, out_valid, S, E, F, sat
    );

    // The converter itself.
    modport slave (
        input  in_valid, D, out_ready,
        output in_ready, out_valid, S, E, F, sat
    );
endinterface

// File: rtl/fpcvt_pipe.sv
// Three-stage two's-complement to compact float (S, E, F; value = F * 2^E).
// Stage 1 takes the magnitude, stage 2 normalises, stage 3 rounds
// (nearest, ties away from zero) and saturates. A single global stall
// freezes every stage while the output is held.
module fpcvt_pipe #(
    parameter int unsigned IN_W  = 12,
    parameter int unsigned EXP_W = 3,
    parameter int unsigned MAN_W = 4
) (
    input logic         clk,
    input logic         rst,
    fpcvt_pipe_if.slave bus
);
    localparam int unsigned MAG_W   = IN_W - 1;
    // Exponent math is carried one bit wider so overflow is visible.
    localparam int unsigned EW      = EXP_W + 1;
    localparam int unsigned EXP_CAP = 2**EW - 1;
    localparam logic [EW-1:0] EMAX_E = EW'(2**EXP_W - 1);

    logic adv;

    // Stage 1 registers
    logic             v1_q, s1_q, sat1_q;
    logic [MAG_W-1:0] m1_q;
    logic [IN_W-1:0]  mag_full;
    logic             most_neg;
    logic [MAG_W-1:0] m1_d;

    // Stage 2 registers
    logic             v2_q, s2_q, sat2_q, rnd2_q;
    logic [MAN_W-1:0] f2_q;
    logic [EW-1:0]    e2_q;
    logic [MAN_W-1:0] f2_d;
    logic [EW-1:0]    e2_d;
    logic             rnd2_d;

    // Stage 3 (output) registers
    logic             v3_q, s3_q, sat3_q;
    logic [EXP_W-1:0] e3_q;
    logic [MAN_W-1:0] f3_q;
    logic [EXP_W-1:0] e3_d;
    logic [MAN_W-1:0] f3_d;
    logic             sat3_d;

    logic [MAN_W:0]   f_sum;
    logic [EW-1:0]    e_r;
    logic [MAN_W-1:0] f_r;
    logic             ovf;

    // Whole pipeline moves unless the output is valid and not being taken.
    assign adv          = !(v3_q && !bus.out_ready);
    assign bus.in_ready = adv;

    assign bus.out_valid = v3_q;
    assign bus.S         = s3_q;
    assign bus.E         = e3_q;
    assign bus.F         = f3_q;
    assign bus.sat       = sat3_q;

    // Stage 1: sign and magnitude; the most-negative input has no positive
    // twin, so clamp it to the largest magnitude and flag saturation.
    always_comb begin
        mag_full = bus.D[IN_W-1] ? (~bus.D + IN_W'(1)) : bus.D;
        most_neg = bus.D[IN_W-1] && (bus.D[IN_W-2:0] == '0);
        m1_d     = most_neg ? '1 : mag_full[MAG_W-1:0];
    end

    // Stage 2: find the leading one and shift it to the top of F.
    always_comb begin
        int unsigned      p;
        int unsigned      sh;
        logic [MAG_W-1:0] tmp;
        logic [MAG_W-1:0] rtmp;
        p      = 0;
        sh     = 0;
        tmp    = '0;
        rtmp   = '0;
        f2_d   = '0;
        e2_d   = '0;
        rnd2_d = 1'b0;
        for (int unsigned i = 0; i < MAG_W; i++) begin
            tmp = m1_q >> i;
            if (tmp[0]) p = i;
        end
        if (m1_q == '0) begin
            f2_d = '0;
        end else if (p < MAN_W) begin
            f2_d = m1_q[MAN_W-1:0];
        end else begin
            sh     = p - MAN_W + 1;
            tmp    = m1_q >> sh;
            rtmp   = m1_q >> (sh - 1);
            f2_d   = tmp[MAN_W-1:0];
            rnd2_d = rtmp[0];
            e2_d   = (sh > EXP_CAP) ? '1 : EW'(sh);
        end
    end

    // Stage 3: round, renormalise on carry-out, saturate on exponent overflow.
    always_comb begin
        f_sum = {1'b0, f2_q} + {{MAN_W{1'b0}}, rnd2_q};
        e_r   = e2_q;
        f_r   = f_sum[MAN_W-1:0];
        if (f_sum[MAN_W]) begin
            f_r = {1'b1, {(MAN_W-1){1'b0}}};
            e_r = e2_q + EW'(1);
        end
        ovf    = (e2_q > EMAX_E) || (e_r > EMAX_E);
        e3_d   = ovf ? '1 : e_r[EXP_W-1:0];
        f3_d   = ovf ? '1 : f_r;
        sat3_d = ovf || sat2_q;
    end

    // Pipeline registers: reset clears everything, stall holds everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            s1_q   <= 1'b0;
            sat1_q <= 1'b0;
            m1_q   <= '0;
            v2_q   <= 1'b0;
            s2_q   <= 1'b0;
            sat2_q <= 1'b0;
            rnd2_q <= 1'b0;
            f2_q   <= '0;
            e2_q   <= '0;
            v3_q   <= 1'b0;
            s3_q   <= 1'b0;
            sat3_q <= 1'b0;
            e3_q   <= '0;
            f3_q   <= '0;
        end else if (adv) begin
            v1_q   <= bus.in_valid;
            s1_q   <= bus.D[IN_W-1];
            sat1_q <= most_neg;
            m1_q   <= m1_d;
            v2_q   <= v1_q;
            s2_q   <= s1_q;
            sat2_q <= sat1_q;
            rnd2_q <= rnd2_d;
            f2_q   <= f2_d;
            e2_q   <= e2_d;
            v3_q   <= v2_q;
            s3_q   <= s2_q;
            sat3_q <= sat3_d;
            e3_q   <= e3_d;
            f3_q   <= f3_d;
        end
    end
endmodule

// File: tb/tb_fpcvt_pipe.sv
// Bench for fpcvt_pipe: directed spot values, stall/hold, reset mid-flight
// and a full sweep of every input code under random backpressure.
module tb_fpcvt_pipe;
    localparam int unsigned IN_W  = 12;
    localparam int unsigned EXP_W = 3;
    localparam int unsigned MAN_W = 4;

    typedef struct packed {
        logic       s;
        logic [2:0] e;
        logic [3:0] f;
        logic       sat;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fpcvt_pipe_if #(.IN_W(IN_W), .EXP_W(EXP_W), .MAN_W(MAN_W)) bus_if ();

    fpcvt_pipe #(.IN_W(IN_W), .EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    // Reference: value = F * 2^E with the smallest E whose rounded quotient fits.
    function automatic res_t ref_conv(input logic [11:0] d);
        res_t r;
        int   v, m, e, q;
        v     = int'($signed(d));
        r     = '0;
        r.s   = (v < 0);
        m     = (v < 0) ? -v : v;
        if (m > 2047) begin
            m     = 2047;
            r.sat = 1'b1;
        end
        q = m;
        for (e = 0; e < 32; e++) begin
            q = (e == 0) ? m : ((m + (1 << (e - 1))) >> e);
            if (q < 16) break;
        end
        if (e > 7) begin
            r.e   = 3'd7;
            r.f   = 4'd15;
            r.sat = 1'b1;
        end else begin
            r.e = e[2:0];
            r.f = q[3:0];
        end
        return r;
    endfunction

    // One cycle: sample at negedge, return just after the next posedge.
    task automatic tick(output bit acc, output bit dlv, output res_t got,
                        output bit rdy, output bit ov);
        @(negedge clk);
        rdy = bus_if.in_ready;
        ov  = bus_if.out_valid;
        acc = bus_if.in_valid && bus_if.in_ready;
        dlv = bus_if.out_valid && bus_if.out_ready;
        got = {bus_if.S, bus_if.E, bus_if.F, bus_if.sat};
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst              = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        bus_if.D         = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_if.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b expected 0", bus_if.out_valid);
        end
        checks++;
        if (bus_if.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", bus_if.in_ready);
        end
        checks++;
        if ({bus_if.S, bus_if.E, bus_if.F, bus_if.sat} !== 9'd0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 000",
                     {bus_if.S, bus_if.E, bus_if.F, bus_if.sat});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic [11:0] dv [7];
        res_t        ev [7];
        bit          acc, dlv, rdy, ov, found;
        res_t        got, first;
        int          lat;
        dv[0] = 12'd422;  ev[0] = '{s: 1'b0, e: 3'd5, f: 4'd13, sat: 1'b0};
        dv[1] = 12'hE5A;  ev[1] = '{s: 1'b1, e: 3'd5, f: 4'd13, sat: 1'b0};
        dv[2] = 12'd125;  ev[2] = '{s: 1'b0, e: 3'd4, f: 4'd8,  sat: 1'b0};
        dv[3] = 12'd7;    ev[3] = '{s: 1'b0, e: 3'd0, f: 4'd7,  sat: 1'b0};
        dv[4] = 12'd0;    ev[4] = '{s: 1'b0, e: 3'd0, f: 4'd0,  sat: 1'b0};
        dv[5] = 12'h7FF;  ev[5] = '{s: 1'b0, e: 3'd7, f: 4'd15, sat: 1'b1};
        dv[6] = 12'h800;  ev[6] = '{s: 1'b1, e: 3'd7, f: 4'd15, sat: 1'b1};
        bus_if.out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            bus_if.D        = dv[k];
            bus_if.in_valid = 1'b1;
            tick(acc, dlv, got, rdy, ov);
            bus_if.in_valid = 1'b0;
            found = 1'b0;
            lat   = 0;
            first = '0;
            for (int n = 1; n <= 8; n++) begin
                tick(acc, dlv, got, rdy, ov);
                if (dlv && !found) begin
                    found = 1'b1;
                    lat   = n;
                    first = got;
                end
            end
            checks++;
            if (lat != 3) begin
                errors++;
                $display("FAIL latency D=%h: got %0d expected 3", dv[k], lat);
            end
            checks++;
            if (first !== ev[k]) begin
                errors++;
                $display("FAIL directed D=%h: got S%b E%0d F%0d sat%b expected S%b E%0d F%0d sat%b",
                         dv[k], first.s, first.e, first.f, first.sat,
                         ev[k].s, ev[k].e, ev[k].f, ev[k].sat);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] dat [8];
        res_t        q [$];
        res_t        got, held, exp_r;
        bit          acc, dlv, rdy, ov;
        int          idx, delivered;
        for (int i = 0; i < 8; i++) dat[i] = 12'($urandom_range(0, 4095));
        idx       = 0;
        delivered = 0;
        held      = '0;
        for (int c = 0; c < 40 && delivered < 8; c++) begin
            bus_if.out_ready = !(c >= 4 && c <= 6);
            bus_if.in_valid  = (idx < 8);
            bus_if.D         = (idx < 8) ? dat[idx] : 12'd0;
            tick(acc, dlv, got, rdy, ov);
            if (c >= 4 && c <= 6) begin
                checks++;
                if (rdy !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_in_ready c=%0d: got %b expected 0", c, rdy);
                end
            end
            if (c == 4) held = got;
            if (c == 5 || c == 6) begin
                checks++;
                if (got !== held) begin
                    errors++;
                    $display("FAIL b2b_hold c=%0d: got %h expected %h", c, got, held);
                end
            end
            if (acc) begin
                q.push_back(ref_conv(dat[idx]));
                idx++;
            end
            if (dlv) begin
                exp_r = (q.size() > 0) ? q.pop_front() : '0;
                checks++;
                if (got !== exp_r) begin
                    errors++;
                    $display("FAIL b2b_data #%0d: got %h expected %h", delivered, got, exp_r);
                end
                delivered++;
            end
        end
        checks++;
        if (delivered != 8 || idx != 8) begin
            errors++;
            $display("FAIL b2b_count: got %0d delivered %0d accepted expected 8 8",
                     delivered, idx);
        end
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
    endtask

    task automatic test_reset_flight();
        res_t got;
        bit   acc, dlv, rdy, ov;
        int   stale;
        bus_if.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus_if.in_valid = 1'b1;
            bus_if.D        = 12'($urandom_range(1, 2047));
            tick(acc, dlv, got, rdy, ov);
        end
        // Full pipe: hold the output so nothing escapes before reset hits.
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        rst              = 1'b1;
        tick(acc, dlv, got, rdy, ov);
        rst              = 1'b0;
        bus_if.out_ready = 1'b1;
        tick(acc, dlv, got, rdy, ov);
        checks++;
        if (ov !== 1'b0) begin
            errors++;
            $display("FAIL flight_out_valid: got %b expected 0", ov);
        end
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("FAIL flight_in_ready: got %b expected 1", rdy);
        end
        checks++;
        if (got !== 9'd0) begin
            errors++;
            $display("FAIL flight_data: got %h expected 000", got);
        end
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            tick(acc, dlv, got, rdy, ov);
            if (dlv) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL flight_stale: got %0d results expected 0", stale);
        end
    endtask

    task automatic test_random_sweep();
        res_t q [$];
        res_t got, prev, exp_r;
        bit   acc, dlv, rdy, ov, stalled;
        int   nxt, delivered;
        nxt       = 0;
        delivered = 0;
        stalled   = 1'b0;
        prev      = '0;
        for (int cyc = 0; cyc < 40000 && delivered < 4096; cyc++) begin
            bus_if.in_valid  = (nxt < 4096) && ($urandom_range(0, 9) < 8);
            bus_if.D         = nxt[11:0];
            bus_if.out_ready = ($urandom_range(0, 9) < 7);
            tick(acc, dlv, got, rdy, ov);
            if (stalled) begin
                checks++;
                if (!ov || got !== prev) begin
                    errors++;
                    $display("FAIL sweep_hold cyc=%0d: got v%b %h expected v1 %h",
                             cyc, ov, got, prev);
                end
            end
            stalled = ov && !dlv;
            prev    = got;
            if (acc) begin
                q.push_back(ref_conv(nxt[11:0]));
                nxt++;
            end
            if (dlv) begin
                exp_r = (q.size() > 0) ? q.pop_front() : '0;
                checks++;
                if (got !== exp_r) begin
                    errors++;
                    $display("FAIL sweep_data #%0d: got %h expected %h", delivered, got, exp_r);
                end
                delivered++;
            end
        end
        checks++;
        if (delivered != 4096) begin
            errors++;
            $display("FAIL sweep_count: got %0d expected 4096", delivered);
        end
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
    endtask

    initial begin
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        bus_if.D         = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_flight();
        test_random_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
